// File: rtl/proto_serialize.sv
// Protobuf wire-format field encoder: one field descriptor in, key varint plus
// value bytes out through a single-entry output register with valid/ready flow.
module proto_serialize #(
  parameter int MAX_VARINT_BYTES = 10,
  parameter int LEN_W            = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        field_valid_i,
  output logic        field_ready_o,
  input  logic [4:0]  fieldNumber_i,
  input  logic [2:0]  wireType_i,
  input  logic [63:0] field_val_i,
  input  logic [7:0]  data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic [7:0]  protoStream_o,
  output logic        protoStream_valid_o,
  input  logic        protoStream_ready_i,
  output logic        field_done_o,
  output logic        error_o
);

  localparam int IDX_W = (MAX_VARINT_BYTES > 8) ? $clog2(MAX_VARINT_BYTES + 1) : 4;

  typedef enum logic [2:0] {IDLE, KEY, VARINT, FIXED, LEN, PAYLOAD} state_t;

  state_t           r_state,     w_state_nxt;
  logic [7:0]       r_out,       w_out_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [2:0]       r_wt,        w_wt_nxt;
  logic [63:0]      r_rem,       w_rem_nxt;
  logic [IDX_W-1:0] r_idx,       w_idx_nxt;
  logic [LEN_W-1:0] r_cnt,       w_cnt_nxt;
  logic             r_fin,       w_fin_nxt;
  logic             r_err,       w_err_nxt;

  logic        w_can_load;
  logic        w_done;
  logic        w_vlast;
  logic        w_wt_ok;
  logic        w_data_ready;
  logic [63:0] w_rem_shr;
  logic [7:0]  w_key;

  function automatic state_t value_state(input logic [2:0] wt);
    case (wt)
      3'd0:    value_state = VARINT;
      3'd2:    value_state = LEN;
      default: value_state = FIXED;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    w_can_load   = !r_out_valid || protoStream_ready_i;
    w_done       = r_fin && r_out_valid && protoStream_ready_i && !reset_i;
    w_rem_shr    = r_rem >> 7;
    w_vlast      = (w_rem_shr == 64'd0) || (r_idx == IDX_W'(MAX_VARINT_BYTES - 1));
    w_key        = {fieldNumber_i, wireType_i};
    w_wt_ok      = (wireType_i == 3'd0) || (wireType_i == 3'd1) ||
                   (wireType_i == 3'd2) || (wireType_i == 3'd5);
    w_data_ready = (r_state == PAYLOAD) && !r_fin && w_can_load && !reset_i;

    w_state_nxt     = r_state;
    w_out_nxt       = r_out;
    w_out_valid_nxt = r_out_valid && !protoStream_ready_i;
    w_wt_nxt        = r_wt;
    w_rem_nxt       = r_rem;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_fin_nxt       = r_fin;
    w_err_nxt       = 1'b0;

    case (r_state)
      IDLE: begin
        if (field_valid_i) begin
          if (w_wt_ok && (fieldNumber_i != 5'd0)) begin
            // The first key varint byte equals the key itself: bit 7 doubles as the continuation flag.
            w_out_nxt       = w_key;
            w_out_valid_nxt = 1'b1;
            w_wt_nxt        = wireType_i;
            w_rem_nxt       = (wireType_i == 3'd2) ? 64'(field_val_i[LEN_W-1:0]) : field_val_i;
            w_cnt_nxt       = field_val_i[LEN_W-1:0];
            w_idx_nxt       = (wireType_i == 3'd1) ? IDX_W'(8) :
                              (wireType_i == 3'd5) ? IDX_W'(4) : '0;
            w_fin_nxt       = 1'b0;
            w_state_nxt     = w_key[7] ? KEY : value_state(wireType_i);
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      KEY: begin
        if (w_can_load) begin
          w_out_nxt       = 8'h01;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = value_state(r_wt);
        end
      end
      VARINT, LEN: begin
        if (!r_fin && w_can_load) begin
          w_out_nxt       = {!w_vlast, r_rem[6:0]};
          w_out_valid_nxt = 1'b1;
          w_rem_nxt       = w_rem_shr;
          w_idx_nxt       = r_idx + IDX_W'(1);
          if (w_vlast) begin
            if ((r_state == LEN) && (r_cnt != '0)) begin
              w_state_nxt = PAYLOAD;
            end else begin
              w_fin_nxt = 1'b1;
            end
          end
        end
      end
      FIXED: begin
        if (!r_fin && w_can_load) begin
          w_out_nxt       = r_rem[7:0];
          w_out_valid_nxt = 1'b1;
          w_rem_nxt       = r_rem >> 8;
          w_idx_nxt       = r_idx - IDX_W'(1);
          if (r_idx == IDX_W'(1)) begin
            w_fin_nxt = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (w_data_ready && data_valid_i) begin
          w_out_nxt       = data_i;
          w_out_valid_nxt = 1'b1;
          w_cnt_nxt       = r_cnt - LEN_W'(1);
          if (r_cnt == LEN_W'(1)) begin
            w_fin_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // r_fin marks the byte held in the output register as the field's last one.
    if (w_done) begin
      w_state_nxt = IDLE;
      w_fin_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (reset_i) begin
      r_state     <= IDLE;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_wt        <= '0;
      r_rem       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_fin       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_wt        <= w_wt_nxt;
      r_rem       <= w_rem_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fin       <= w_fin_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign field_ready_o       = (r_state == IDLE) && !reset_i;
  assign data_ready_o        = w_data_ready;
  assign protoStream_o       = r_out;
  assign protoStream_valid_o = r_out_valid;
  assign field_done_o        = w_done;
  assign error_o             = r_err;

endmodule

// File: tb/tb_proto_serialize.sv
// Self-checking bench for proto_serialize: a queue-based wire-format model
// predicts every output byte; directed literals pin the model itself.
module tb_proto_serialize;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        field_valid_i;
  logic        field_ready_o;
  logic [4:0]  fieldNumber_i;
  logic [2:0]  wireType_i;
  logic [63:0] field_val_i;
  logic [7:0]  data_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [7:0]  protoStream_o;
  logic        protoStream_valid_o;
  logic        protoStream_ready_i;
  logic        field_done_o;
  logic        error_o;

  proto_serialize dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .field_valid_i       (field_valid_i),
    .field_ready_o       (field_ready_o),
    .fieldNumber_i       (fieldNumber_i),
    .wireType_i          (wireType_i),
    .field_val_i         (field_val_i),
    .data_i              (data_i),
    .data_valid_i        (data_valid_i),
    .data_ready_o        (data_ready_o),
    .protoStream_o       (protoStream_o),
    .protoStream_valid_o (protoStream_valid_o),
    .protoStream_ready_i (protoStream_ready_i),
    .field_done_o        (field_done_o),
    .error_o             (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] fixed_pay[$];
  logic [7:0] cap_q[$];
  int         cap_cyc[$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int n_done = 0, n_err = 0, n_dhs = 0;
  int n_done_exp = 0, n_err_exp = 0;
  int acc_cyc = 0;
  int rdy_mode = 0;
  bit bubbles = 1'b0;
  bit dhs_last = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_b = '0;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain varint / little-endian encoding of a whole field.
  function automatic void push_varint(input logic [63:0] v, input bit last_field);
    exp_t e;
    forever begin
      e.b    = {1'b0, v[6:0]};
      v      = v >> 7;
      e.b[7] = (v != 64'd0);
      e.last = last_field && (v == 64'd0);
      exp_q.push_back(e);
      if (v == 64'd0) break;
    end
  endfunction

  function automatic void push_byte(input logic [7:0] b, input bit last);
    exp_t e;
    e.b    = b;
    e.last = last;
    exp_q.push_back(e);
  endfunction

  task automatic send_field(input logic [4:0] fn, input logic [2:0] wt, input logic [63:0] val);
    logic [7:0] p[$];
    int  len;
    int  k;
    int  nb;
    bit  good;
    good = (fn != 5'd0) && (wt == 3'd0 || wt == 3'd1 || wt == 3'd2 || wt == 3'd5);
    if (!good) begin
      n_err_exp++;
    end else begin
      n_done_exp++;
      push_varint(64'(fn) * 8 + 64'(wt), 1'b0);
      case (wt)
        3'd0: push_varint(val, 1'b1);
        3'd2: begin
          len = int'(val[15:0]);
          for (int i = 0; i < len; i++) begin
            if (fixed_pay.size() != 0) p.push_back(fixed_pay.pop_front());
            else p.push_back(8'($urandom));
          end
          fixed_pay.delete();
          push_varint(64'(len), len == 0);
          for (int i = 0; i < len; i++) begin
            push_byte(p[i], i == len - 1);
            pay_q.push_back(p[i]);
          end
        end
        default: begin
          nb = (wt == 3'd1) ? 8 : 4;
          for (int i = 0; i < nb; i++) push_byte(val[8*i +: 8], i == nb - 1);
        end
      endcase
    end
    fieldNumber_i = fn;
    wireType_i    = wt;
    field_val_i   = val;
    field_valid_i = 1'b1;
    k = 0;
    forever begin
      @(negedge clk_i);
      if (field_ready_o) break;
      k++;
      if (k > 3000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: field_ready_o low for %0d cycles, required 1", k);
        break;
      end
    end
    acc_cyc = cyc + 1;
    @(posedge clk_i);
    #1;
    field_valid_i = 1'b0;
    fieldNumber_i = 5'($urandom);
    wireType_i    = 3'($urandom);
    field_val_i   = {$urandom, $urandom};
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && pay_q.size() == 0 && field_ready_o)) begin
      @(negedge clk_i);
      k++;
      if (k > 3000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain_timeout: %0d bytes still expected, required 0", exp_q.size());
        break;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_cap(input string name, input int n, input logic [127:0] v);
    check({name, "_count"}, 64'(cap_q.size()), 64'(n));
    for (int i = 0; i < n && i < cap_q.size(); i++) begin
      check(name, 64'(cap_q[i]), 64'(v[8*(n-1-i) +: 8]));
    end
    cap_q.delete();
    cap_cyc.delete();
  endtask

  // Compare process: every downstream handshake is checked against the model.
  always @(negedge clk_i) begin
    exp_t e;
    if (reset_i) begin
      prev_stall = 1'b0;
      dhs_last   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(protoStream_valid_o), 64'd1);
        check("hold_data", 64'(protoStream_o), 64'(prev_b));
      end
      if (protoStream_valid_o && protoStream_ready_i) begin
        cap_q.push_back(protoStream_o);
        cap_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_byte: got %02h, required no byte", protoStream_o);
        end else begin
          e = exp_q.pop_front();
          check("stream_byte", 64'(protoStream_o), 64'(e.b));
          check("field_done", 64'(field_done_o), 64'(e.last));
        end
      end else begin
        check("done_quiet", 64'(field_done_o), 64'd0);
      end
      if (field_done_o) n_done++;
      if (error_o) n_err++;
      dhs_last = data_valid_i && data_ready_o;
      if (dhs_last) n_dhs++;
      prev_stall = protoStream_valid_o && !protoStream_ready_i;
      prev_b     = protoStream_o;
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (rdy_mode == 0) protoStream_ready_i = 1'b1;
    else if (rdy_mode == 1) protoStream_ready_i = ($urandom_range(0, 3) != 0);
  end

  always @(posedge clk_i) begin
    #1;
    if (reset_i) begin
      pay_q.delete();
      data_valid_i = 1'b0;
    end else begin
      if (dhs_last && pay_q.size() != 0) void'(pay_q.pop_front());
      if (pay_q.size() != 0 && (!bubbles || $urandom_range(0, 3) != 0)) begin
        data_valid_i = 1'b1;
        data_i       = pay_q[0];
      end else begin
        data_valid_i = 1'b0;
        data_i       = 8'($urandom);
      end
    end
  end

  initial begin
    logic [55:0] testing;
    int          d0, h0, e0, c0, c2, k;
    reset_i = 1'b1;
    field_valid_i = 1'b0;
    fieldNumber_i = '0;
    wireType_i = '0;
    field_val_i = '0;
    data_i = '0;
    data_valid_i = 1'b0;
    protoStream_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_field_ready", 64'(field_ready_o), 64'd0);
    check("rst_valid", 64'(protoStream_valid_o), 64'd0);
    check("rst_done", 64'(field_done_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_data_ready", 64'(data_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_field_ready", 64'(field_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    cap_q.delete();
    cap_cyc.delete();

    // Varint 150 with ready tied high: three consecutive bytes.
    d0 = n_done;
    send_field(5'd1, 3'd0, 64'd150);
    drain();
    c0 = (cap_cyc.size() >= 3) ? cap_cyc[0] : -100;
    c2 = (cap_cyc.size() >= 3) ? cap_cyc[2] : -100;
    check("varint150_latency", 64'(c0), 64'(acc_cyc));
    check("varint150_span", 64'(c2 - c0), 64'd2);
    check("varint150_done_count", 64'(n_done - d0), 64'd1);
    check_cap("varint150", 3, 128'h089601);

    // Length-delimited "testing" with payload bubbles.
    bubbles = 1'b1;
    testing = 56'h74657374696E67;
    for (int i = 0; i < 7; i++) fixed_pay.push_back(testing[8*(6-i) +: 8]);
    h0 = n_dhs;
    send_field(5'd2, 3'd2, 64'd7);
    drain();
    check("testing_data_handshakes", 64'(n_dhs - h0), 64'd7);
    check_cap("testing", 9, 128'h12_07_74_65_73_74_69_6E_67);

    send_field(5'd16, 3'd0, 64'd1);
    drain();
    check_cap("two_byte_key", 3, 128'h800101);
    send_field(5'd1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    check_cap("max_varint", 11, 128'h08_FFFFFFFFFFFFFFFFFF_01);
    send_field(5'd3, 3'd5, 64'h1234_5678);
    drain();
    check_cap("fixed32", 5, 128'h1D78563412);
    send_field(5'd4, 3'd1, 64'd1);
    drain();
    check_cap("fixed64", 9, 128'h21_01_00000000000000);

    // Downstream stall of three cycles on the second byte.
    rdy_mode = 2;
    protoStream_ready_i = 1'b1;
    send_field(5'd1, 3'd0, 64'd150);
    @(posedge clk_i);
    #1;
    protoStream_ready_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    protoStream_ready_i = 1'b1;
    rdy_mode = 0;
    drain();
    check_cap("backpressure150", 3, 128'h089601);

    d0 = n_done;
    send_field(5'd2, 3'd2, 64'd0);
    drain();
    check("len0_done_count", 64'(n_done - d0), 64'd1);
    check_cap("len0", 2, 128'h1200);

    // Unsupported wire type and field number zero.
    e0 = n_err;
    send_field(5'd1, 3'd3, 64'd5);
    @(negedge clk_i);
    check("wt3_error_pulse", 64'(error_o), 64'd1);
    check("wt3_field_ready", 64'(field_ready_o), 64'd1);
    check("wt3_no_output", 64'(protoStream_valid_o), 64'd0);
    @(negedge clk_i);
    check("wt3_error_single", 64'(error_o), 64'd0);
    @(posedge clk_i);
    #1;
    send_field(5'd0, 3'd0, 64'd5);
    drain();
    check("error_count", 64'(n_err - e0), 64'd2);
    check_cap("error_no_bytes", 0, 128'h0);

    // Reset in the middle of a payload.
    bubbles = 1'b0;
    h0 = n_dhs;
    send_field(5'd7, 3'd2, 64'd10);
    k = 0;
    while (n_dhs - h0 < 3 && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    check("reset_test_reached_payload", 64'(n_dhs - h0 >= 3), 64'd1);
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("midrst_valid", 64'(protoStream_valid_o), 64'd0);
    check("midrst_data_ready", 64'(data_ready_o), 64'd0);
    check("midrst_field_ready", 64'(field_ready_o), 64'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    exp_q.delete();
    cap_q.delete();
    cap_cyc.delete();
    n_done_exp--;
    repeat (2) @(negedge clk_i);
    check("after_rst_field_ready", 64'(field_ready_o), 64'd1);
    check("after_rst_valid", 64'(protoStream_valid_o), 64'd0);
    @(posedge clk_i);
    #1;

    // Randomized back-to-back fields with random backpressure and payload bubbles.
    rdy_mode = 1;
    bubbles  = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [4:0]  fn;
      logic [2:0]  wt;
      logic [63:0] val;
      int          r;
      fn = 5'($urandom_range(0, 31));
      r  = $urandom_range(0, 9);
      wt = (r < 3) ? 3'd0 : (r < 5) ? 3'd1 : (r < 7) ? 3'd5 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 4));
      if (r == 9 && $urandom_range(0, 1) == 1) wt = 3'($urandom_range(6, 7));
      val = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (wt == 3'd2) begin
        val[15:0] = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(128, 300)) : 16'($urandom_range(0, 12));
      end
      send_field(fn, wt, val);
    end
    drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check("total_done", 64'(n_done), 64'(n_done_exp));
    check("total_errors", 64'(n_err), 64'(n_err_exp));
    check("leftover_expected", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
